fpm_round_stage: RTL and testbench
==================================

# fpm_round_stage

Final pipeline stage of the floating-point multiplier. It consumes the raw product from the mantissa-multiply stage: sign, unbiased-plus-bias exponent sum and the full 48-bit significand product. It normalizes, rounds to nearest-even, detects overflow and underflow, and packs an IEEE-754 single-precision result. It is a two-stage elastic pipeline with valid/ready on both sides, so the multiplier core can be back-pressured by downstream logic such as the factorial sequencer.

## Interface
- EXP_WIDTH, 8, exponent field width
- MANTISSA_WIDTH, 23, stored fraction width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream holds a product
- in_ready  out  1  stage accepts this cycle
- in_sign  in  1  product sign (sign_a ^ sign_b)
- in_exp  in  EXP_WIDTH+2  signed; ea + eb - bias (biased result exponent before normalization)
- in_prod  in  2*(MANTISSA_WIDTH+1)  product of hidden-bit significands, range [1,4)
- in_nan  in  1  result is NaN
- in_invalid  in  1  NaN is from an invalid operation (inf*0)
- in_inf  in  1  result is infinity
- in_zero  in  1  result is zero (zero or subnormal operand; DAZ upstream)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_result  out  EXP_WIDTH+MANTISSA_WIDTH+1  packed result
- out_flags  out  4  {invalid, overflow, underflow, inexact}

## Operation
- Transfers:
  - Input transfer occurs on in_valid & in_ready.
  - Output transfer occurs on out_valid & out_ready.
- Stage S1 (normalize), registered:
  - If in_prod[47]: fraction = prod[46:24], guard = prod[23], sticky = |prod[22:0], e = in_exp + 1.
  - Else: fraction = prod[45:23], guard = prod[22], sticky = |prod[21:0], e = in_exp.
  - Special flags, sign and the result are captured.
- Stage S2 (round/pack), registered:
  - Round up when guard & (sticky | fraction[0]).
  - A fraction carry-out sets fraction = 0 and e += 1.
  - inexact = guard | sticky.
- Range checks on the final e, as signed EXP_WIDTH+2 arithmetic:
  - e ≥ 255: result is {sign, 0xFF, 0}; overflow = 1, inexact = 1.
  - e ≤ 0: result is {sign, 0, 0} (flush to zero, no subnormal output); underflow = 1, inexact = 1.
- Special priority: nan > inf > zero > normal.
  - nan: result 0x7FC00000; invalid = in_invalid; other flags 0.
  - inf: {sign, 0xFF, 0}; flags 0.
  - zero: {sign, 0, 0}; flags 0.
- Ordering: results leave in acceptance order. There is no drop and no duplication.

## Timing
- Latency is 2 cycles from input transfer to out_valid when not stalled. Throughput is 1 result per cycle.
- Ready logic:
  - s2_adv = ~s2_valid | out_ready
  - s1_adv = ~s1_valid | s2_adv
  - in_ready = s1_adv. This is a combinational ready chain; no skid buffer is required.
- Under stall, S1 and S2 hold their contents. out_result and out_flags stay stable while out_valid & ~out_ready.
- A simultaneous input and output transfer with both stages full advances the whole pipe with no bubble.
- Reset, asserted asynchronously including mid-operation:
  - s1_valid = 0, s2_valid = 0, out_valid = 0.
  - out_result = 0, out_flags = 0.
  - in_ready reads 1 during and immediately after reset.
  - In-flight items are discarded.
- Data registers update only on their stage's advance, which keeps switching low.

## Structure
- Shared package fpm_pkg holds:
  - EXP_WIDTH, MANTISSA_WIDTH, BIAS = 127.
  - EMAX = 255 and QNAN = 32'h7FC00000.
  - typedef fp_flags_t for the 4-bit flag struct.
  - typedef fp_raw_t for the S1 payload (sign, e, fraction, guard, sticky, specials).
- One sub-module is natural: fpm_rne_pack. It is purely combinational, takes fp_raw_t and returns the packed result plus flags. It is instanced between the S1 and S2 registers.

## Test plan
- 1.5 × 1.5: in_prod = 0x900000000000, in_exp = 127, out_ready = 1 → after 2 cycles out_result = 0x40100000, flags = 0.
- Tie-to-even:
  - in_prod = 0x400000400000, in_exp = 127 → 0x3F800000 with inexact = 1.
  - in_prod = 0x400000C00000 → 0x3F800002 with inexact = 1.
- Overflow: in_prod[47] = 1, in_exp = 254 → 0x7F800000 (sign 0) with overflow = 1, inexact = 1. Underflow: in_exp = 0, in_prod = 0x400000000000 → 0x00000000 with underflow = 1, inexact = 1.
- Specials:
  - in_nan = 1, in_invalid = 1, in_inf = 1 together → 0x7FC00000 with invalid only.
  - in_sign = 1, in_zero = 1 → 0x80000000.
- Backpressure: stream 5 products back-to-back with out_ready low for cycles 2–7.
  - in_ready drops once both stages are full.
  - Outputs are held stable, all 5 emerge in order, and none are lost.
- Reset mid-stream: assert rst_n low while 2 items are in flight → out_valid is 0 immediately. After release, a new item appears exactly 2 cycles after acceptance.

Source files
------------

// File: rtl/fpm_pkg.sv
// Shared types and constants for the single-precision multiplier's round stage.
// Widths are fixed here so the pipeline registers and the packer agree on fp_raw_t.
package fpm_pkg;
  localparam int EXP_WIDTH      = 8;
  localparam int MANTISSA_WIDTH = 23;
  localparam int EW2            = EXP_WIDTH + 2;
  localparam int PROD_W         = 2 * (MANTISSA_WIDTH + 1);
  localparam int RES_W          = EXP_WIDTH + MANTISSA_WIDTH + 1;
  localparam int BIAS           = 127;
  localparam int EMAX           = 2 * BIAS + 1;
  localparam logic [RES_W-1:0] QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  typedef struct packed {
    logic                      sign;
    logic [EW2-1:0]            e;
    logic [MANTISSA_WIDTH-1:0] frac;
    logic                      guard;
    logic                      sticky;
    logic                      nan;
    logic                      invalid;
    logic                      inf;
    logic                      zero;
  } fp_raw_t;
endpackage

// File: rtl/fpm_rne_pack.sv
// Round-to-nearest-even, range check and IEEE-754 single packing of a normalized product.
// Purely combinational; sits between the normalize and output registers.
module fpm_rne_pack
  import fpm_pkg::*;
(
  input  fp_raw_t          raw,
  output logic [RES_W-1:0] result,
  output fp_flags_t        flags
);
  localparam logic [EW2-1:0] EMAX_E = EW2'(EMAX);

  logic                    round_up;
  logic [MANTISSA_WIDTH:0] frac_rnd;
  logic [EW2-1:0]          e_fin;
  logic                    inexact;

  always_comb begin
    round_up = raw.guard & (raw.sticky | raw.frac[0]);
    // On carry-out the low bits are already all zero, so only the exponent needs bumping.
    frac_rnd = {1'b0, raw.frac} + {{MANTISSA_WIDTH{1'b0}}, round_up};
    e_fin    = raw.e + {{(EW2-1){1'b0}}, frac_rnd[MANTISSA_WIDTH]};
    inexact  = raw.guard | raw.sticky;
    result   = '0;
    flags    = '0;
    if (raw.nan) begin
      result        = QNAN;
      flags.invalid = raw.invalid;
    end else if (raw.inf) begin
      result = {raw.sign, {EXP_WIDTH{1'b1}}, {MANTISSA_WIDTH{1'b0}}};
    end else if (raw.zero) begin
      result = {raw.sign, {(RES_W-1){1'b0}}};
    end else if (!e_fin[EW2-1] && (e_fin >= EMAX_E)) begin
      result         = {raw.sign, {EXP_WIDTH{1'b1}}, {MANTISSA_WIDTH{1'b0}}};
      flags.overflow = 1'b1;
      flags.inexact  = 1'b1;
    end else if (e_fin[EW2-1] || (e_fin == '0)) begin
      result          = {raw.sign, {(RES_W-1){1'b0}}};
      flags.underflow = 1'b1;
      flags.inexact   = 1'b1;
    end else begin
      result        = {raw.sign, e_fin[EXP_WIDTH-1:0], frac_rnd[MANTISSA_WIDTH-1:0]};
      flags.inexact = inexact;
    end
  end
endmodule

// File: rtl/fpm_round_stage.sv
// Two-stage elastic normalize/round/pack stage of the FP multiplier (S1 normalize, S2 packed result).
// Latency 2, throughput 1; combinational ready chain, both stages hold under stall.
module fpm_round_stage
  import fpm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EW2-1:0]    in_exp,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_nan,
  input  logic              in_invalid,
  input  logic              in_inf,
  input  logic              in_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_result,
  output logic [3:0]        out_flags
);
  logic              s1_vld_q, s1_vld_d;
  logic              s2_vld_q, s2_vld_d;
  logic              s1_adv, s2_adv;
  fp_raw_t           s1_raw_q, s1_raw_d, raw_in;
  logic [RES_W-1:0]  res_q, res_d, pack_res;
  fp_flags_t         flg_q, flg_d, pack_flg;
  logic [PROD_W-2:0] prod_n;

  assign s2_adv   = ~s2_vld_q | out_ready;
  assign s1_adv   = ~s1_vld_q | s2_adv;
  assign in_ready = s1_adv;

  // Left-align so the leading one always sits just above the fraction field.
  always_comb begin
    prod_n        = in_prod[PROD_W-1] ? in_prod[PROD_W-2:0] : {in_prod[PROD_W-3:0], 1'b0};
    raw_in        = '0;
    raw_in.sign   = in_sign;
    raw_in.e      = in_exp + {{(EW2-1){1'b0}}, in_prod[PROD_W-1]};
    raw_in.frac   = prod_n[PROD_W-2 -: MANTISSA_WIDTH];
    raw_in.guard  = prod_n[PROD_W-2-MANTISSA_WIDTH];
    raw_in.sticky = |prod_n[PROD_W-3-MANTISSA_WIDTH:0];
    raw_in.nan     = in_nan;
    raw_in.invalid = in_invalid;
    raw_in.inf     = in_inf;
    raw_in.zero    = in_zero;
  end

  fpm_rne_pack u_pack (
    .raw    (s1_raw_q),
    .result (pack_res),
    .flags  (pack_flg)
  );

  always_comb begin
    s1_vld_d = s1_adv ? in_valid : s1_vld_q;
    s1_raw_d = (s1_adv && in_valid) ? raw_in : s1_raw_q;
    s2_vld_d = s2_adv ? s1_vld_q : s2_vld_q;
    res_d    = (s2_adv && s1_vld_q) ? pack_res : res_q;
    flg_d    = (s2_adv && s1_vld_q) ? pack_flg : flg_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s1_raw_q <= '0;
      res_q    <= '0;
      flg_q    <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      s1_raw_q <= s1_raw_d;
      res_q    <= res_d;
      flg_q    <= flg_d;
    end
  end

  assign out_valid  = s2_vld_q;
  assign out_result = res_q;
  assign out_flags  = flg_q;
endmodule

// File: tb/tb_fpm_round_stage.sv
// Bench for fpm_round_stage: directed corner products plus randomized traffic with random
// output backpressure, scored against an arithmetic remainder-based rounding model.
module tb_fpm_round_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [9:0]  in_exp = '0;
  logic [47:0] in_prod = '0;
  logic        in_nan = 1'b0;
  logic        in_invalid = 1'b0;
  logic        in_inf = 1'b0;
  logic        in_zero = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  fpm_round_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_prod    (in_prod),
    .in_nan     (in_nan),
    .in_invalid (in_invalid),
    .in_inf     (in_inf),
    .in_zero    (in_zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [35:0] exp_q[$];
  logic        rnd_mode = 1'b0;
  logic        saw_full = 1'b0;
  logic        stall_q = 1'b0;
  logic [31:0] held_res;
  logic [3:0]  held_flg;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, want, $time);
  endtask

  // Reference: exact integer rounding of prod / 2^shift, ties to even, flags {inv,ovf,unf,inx}.
  function automatic logic [35:0] model(input logic s, input int e, input logic [47:0] p,
                                        input logic nan, input logic inv, input logic inf,
                                        input logic zero);
    longint unsigned prod, q, rem, half;
    int              sh, ee;
    logic            inx;
    if (nan)  return {32'h7FC00000, inv, 3'b000};
    if (inf)  return {s, 8'hFF, 23'h0, 4'b0000};
    if (zero) return {s, 31'h0, 4'b0000};
    prod = 64'(p);
    sh   = (prod >= (64'd1 << 47)) ? 24 : 23;
    ee   = (sh == 24) ? e + 1 : e;
    q    = prod >> sh;
    rem  = prod - (q << sh);
    half = 64'd1 << (sh - 1);
    inx  = (rem != 0);
    if (rem > half || (rem == half && q[0])) q++;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      ee++;
    end
    if (ee >= 255) return {s, 8'hFF, 23'h0, 4'b0101};
    if (ee <= 0)   return {s, 31'h0, 4'b0011};
    return {s, ee[7:0], q[22:0], 3'b000, inx};
  endfunction

  always @(negedge clk) begin
    logic [35:0] e;
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("hold_result", out_result, held_res);
        chk("hold_flags", 32'(out_flags), 32'(held_flg));
      end
      if (out_valid && out_ready) begin
        chk("out_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("result", out_result, e[35:4]);
          chk("flags", 32'(out_flags), 32'(e[3:0]));
        end
      end
      if (in_valid && !in_ready) saw_full = 1'b1;
      stall_q  = out_valid && !out_ready;
      held_res = out_result;
      held_flg = out_flags;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic s, input logic [9:0] e, input logic [47:0] p,
                      input logic [3:0] sp, input logic [35:0] want);
    int   w = 0;
    logic acc = 1'b0;
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_prod  = p;
    {in_nan, in_invalid, in_inf, in_zero} = sp;
    while (!acc && w < 100) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        exp_q.push_back(want);
      end
      step();
      w++;
    end
    in_valid = 1'b0;
    chk("accepted", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    step();
  endtask

  task automatic check_latency();
    int lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    chk("latency", 32'(lat), 32'd2);
    step();
  endtask

  initial begin
    @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_result", out_result, 32'd0);
    chk("rst_flags", 32'(out_flags), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Directed corners with hand-derived results.
    send(1'b0, 10'd127, 48'h900000000000, 4'b0000, {32'h40100000, 4'b0000});
    check_latency();
    send(1'b0, 10'd127, 48'h400000400000, 4'b0000, {32'h3F800000, 4'b0001});
    send(1'b0, 10'd127, 48'h400000C00000, 4'b0000, {32'h3F800002, 4'b0001});
    send(1'b0, 10'd127, 48'h7FFFFFFFFFFF, 4'b0000, {32'h40000000, 4'b0001});
    send(1'b0, 10'd254, 48'h800000000000, 4'b0000, {32'h7F800000, 4'b0101});
    send(1'b0, 10'd0,   48'h400000000000, 4'b0000, {32'h00000000, 4'b0011});
    send(1'b0, 10'd1,   48'h400000000000, 4'b0000, {32'h00800000, 4'b0000});
    send(1'b1, 10'd127, 48'h400000000000, 4'b1110, {32'h7FC00000, 4'b1000});
    send(1'b1, 10'd127, 48'h400000000000, 4'b0001, {32'h80000000, 4'b0000});
    send(1'b1, 10'd50,  48'h400000000000, 4'b0010, {32'hFF800000, 4'b0000});
    drain();

    // Five back-to-back products with the output stalled for six cycles.
    saw_full = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++)
          send(1'b0, 10'(120 + i), 48'h600000000000 + 48'(i), 4'b0000,
               model(1'b0, 120 + i, 48'h600000000000 + 48'(i), 1'b0, 1'b0, 1'b0, 1'b0));
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_in_ready_drop", 32'(saw_full), 32'd1);

    // Reset while two items are in flight.
    out_ready = 1'b0;
    send(1'b0, 10'd127, 48'h900000000000, 4'b0000, {32'h40100000, 4'b0000});
    send(1'b0, 10'd128, 48'h900000000000, 4'b0000, {32'h40900000, 4'b0000});
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_result", out_result, 32'd0);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(1'b1, 10'd127, 48'h900000000000, 4'b0000, {32'hC0100000, 4'b0000});
    check_latency();
    drain();

    // Randomized traffic with random output stalls.
    rnd_mode = 1'b1;
    for (int n = 0; n < 400; n++) begin
      logic [47:0] p;
      logic [3:0]  sp;
      logic        s;
      int          e, r;
      p = {16'($urandom), $urandom};
      if (!p[47]) p[46] = 1'b1;
      if ($urandom_range(0, 3) == 0) p[21:0] = '0;
      e  = int'($urandom_range(0, 300)) - 20;
      s  = 1'($urandom);
      r  = int'($urandom_range(0, 15));
      sp = {r == 0, 1'($urandom), r == 1, r == 2};
      send(s, 10'(e), p, sp, model(s, e, p, sp[3], sp[2], sp[1], sp[0]));
      if ($urandom_range(0, 3) == 0) step();
    end
    rnd_mode  = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
